// File: rtl/pc_pkg.sv
// Shared program-counter definitions: default address width and the
// decoded control-flow request type with its priority encoder.
package pc_pkg;

  localparam int unsigned PC_WIDTH_DEFAULT = 8;

  typedef enum logic [1:0] {
    REQ_NONE,
    REQ_JMP,
    REQ_CALL,
    REQ_RET
  } ctl_req_t;

  // Return outranks call, call outranks jump.
  function automatic ctl_req_t encode_req(input logic jmp, input logic call, input logic ret);
    if (ret)       return REQ_RET;
    else if (call) return REQ_CALL;
    else if (jmp)  return REQ_JMP;
    else           return REQ_NONE;
  endfunction

  function automatic logic multi_req(input logic jmp, input logic call, input logic ret);
    return (jmp & call) | (jmp & ret) | (call & ret);
  endfunction

endpackage

// File: rtl/call_stack_ctrl_if.sv
// Decoder-facing request bundle and program-counter load outputs of call_stack_ctrl.
interface call_stack_ctrl_if #(
  parameter int unsigned PC_WIDTH = pc_pkg::PC_WIDTH_DEFAULT,
  parameter int unsigned DEPTH    = 8
);
  localparam int unsigned DW = $clog2(DEPTH) + 1;

  logic [PC_WIDTH-1:0] pc;
  logic                jmp_req;
  logic                call_req;
  logic                ret_req;
  logic [PC_WIDTH-1:0] target;
  logic                wr_en;
  logic [PC_WIDTH-1:0] counteradress;
  logic [DW-1:0]       depth;
  logic                empty;
  logic                full;
  logic                err;

  modport master (
    output pc, jmp_req, call_req, ret_req, target,
    input  wr_en, counteradress, depth, empty, full, err
  );

  modport slave (
    input  pc, jmp_req, call_req, ret_req, target,
    output wr_en, counteradress, depth, empty, full, err
  );

endinterface

// File: rtl/addr_stack.sv
// Return-address LIFO: storage array plus depth pointer. The caller must
// never push when full or pop when empty.
module addr_stack #(
  parameter int unsigned PC_WIDTH = pc_pkg::PC_WIDTH_DEFAULT,
  parameter int unsigned DEPTH    = 8,
  localparam int unsigned AW      = $clog2(DEPTH),
  localparam int unsigned DW      = $clog2(DEPTH) + 1
) (
  input  logic                clk,
  input  logic                res,
  input  logic                push,
  input  logic                pop,
  input  logic [PC_WIDTH-1:0] din,
  output logic [PC_WIDTH-1:0] dout,
  output logic [DW-1:0]       depth,
  output logic                empty,
  output logic                full
);

  logic [PC_WIDTH-1:0] mem [DEPTH];
  logic [DW-1:0]       depth_q;
  logic [AW-1:0]       top_idx;

  always_ff @(posedge clk or posedge res) begin
    if (res) begin
      depth_q <= '0;
    end else if (push) begin
      depth_q <= depth_q + DW'(1);
    end else if (pop) begin
      depth_q <= depth_q - DW'(1);
    end
  end

  // Contents are don't-care after reset, so storage carries no reset.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[depth_q[AW-1:0]] <= din;
    end
  end

  assign top_idx = depth_q[AW-1:0] - AW'(1);
  assign dout    = mem[top_idx];
  assign depth   = depth_q;
  assign empty   = (depth_q == '0);
  assign full    = (depth_q == DW'(DEPTH));

endmodule

// File: rtl/call_stack_ctrl.sv
// Control-flow stage ahead of the program counter: turns jump/call/return
// requests into a one-cycle load strobe and address, keeping a return stack.
module call_stack_ctrl
  import pc_pkg::*;
#(
  parameter int unsigned PC_WIDTH = PC_WIDTH_DEFAULT,
  parameter int unsigned DEPTH    = 8
) (
  input logic               clk,
  input logic               res,
  call_stack_ctrl_if.slave  bus
);

  ctl_req_t            req;
  logic                conflict;
  logic                push;
  logic                pop;
  logic [PC_WIDTH-1:0] ret_addr;
  logic [PC_WIDTH-1:0] stack_top;
  logic                stack_empty;
  logic                stack_full;

  logic                wr_en_q,  wr_en_d;
  logic [PC_WIDTH-1:0] addr_q,   addr_d;
  logic                err_q,    err_d;

  addr_stack #(
    .PC_WIDTH (PC_WIDTH),
    .DEPTH    (DEPTH)
  ) u_stack (
    .clk   (clk),
    .res   (res),
    .push  (push),
    .pop   (pop),
    .din   (ret_addr),
    .dout  (stack_top),
    .depth (bus.depth),
    .empty (stack_empty),
    .full  (stack_full)
  );

  // pc of all ones wraps the return address to zero; that is legal.
  assign ret_addr = bus.pc + PC_WIDTH'(1);

  always_comb begin
    req      = encode_req(bus.jmp_req, bus.call_req, bus.ret_req);
    conflict = multi_req(bus.jmp_req, bus.call_req, bus.ret_req);
    push     = 1'b0;
    pop      = 1'b0;
    wr_en_d  = 1'b0;
    addr_d   = addr_q;
    err_d    = err_q | conflict;

    unique case (req)
      REQ_JMP: begin
        wr_en_d = 1'b1;
        addr_d  = bus.target;
      end
      REQ_CALL: begin
        if (stack_full) begin
          err_d = 1'b1;
        end else begin
          push    = 1'b1;
          wr_en_d = 1'b1;
          addr_d  = bus.target;
        end
      end
      REQ_RET: begin
        if (stack_empty) begin
          err_d = 1'b1;
        end else begin
          pop     = 1'b1;
          wr_en_d = 1'b1;
          addr_d  = stack_top;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge res) begin
    if (res) begin
      wr_en_q <= 1'b0;
      addr_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      wr_en_q <= wr_en_d;
      addr_q  <= addr_d;
      err_q   <= err_d;
    end
  end

  assign bus.wr_en         = wr_en_q;
  assign bus.counteradress = addr_q;
  assign bus.err           = err_q;
  assign bus.empty         = stack_empty;
  assign bus.full          = stack_full;

endmodule

// File: tb/tb_call_stack_ctrl.sv
// Self-checking bench for call_stack_ctrl: directed scenarios plus random
// request streams against a queue-based reference model.
module tb_call_stack_ctrl;

  localparam int unsigned PW = 8;
  localparam int unsigned D  = 8;

  logic clk = 1'b0;
  logic res = 1'b1;

  call_stack_ctrl_if #(.PC_WIDTH(PW), .DEPTH(D)) bus ();

  call_stack_ctrl #(.PC_WIDTH(PW), .DEPTH(D)) dut (
    .clk (clk),
    .res (res),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model state
  int q[$];
  int m_wr;
  int m_addr;
  int m_err;

  task automatic chk(input string tag, input int obs, input int exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic check_all();
    chk("wr_en", int'(bus.wr_en), m_wr);
    chk("counteradress", int'(bus.counteradress), m_addr);
    chk("depth", int'(bus.depth), q.size());
    chk("empty", int'(bus.empty), (q.size() == 0) ? 1 : 0);
    chk("full", int'(bus.full), (q.size() == D) ? 1 : 0);
    chk("err", int'(bus.err), m_err);
  endtask

  task automatic model_reset();
    q.delete();
    m_wr   = 0;
    m_addr = 0;
    m_err  = 0;
  endtask

  // One clock: drive requests, let the edge sample them, update model, compare.
  task automatic step(input bit j, input bit c, input bit r, input int p, input int t);
    bus.jmp_req  = j;
    bus.call_req = c;
    bus.ret_req  = r;
    bus.pc       = p[PW-1:0];
    bus.target   = t[PW-1:0];
    @(posedge clk);
    #1;
    if ((int'(j) + int'(c) + int'(r)) > 1) m_err = 1;
    m_wr = 0;
    if (r) begin
      if (q.size() == 0) m_err = 1;
      else begin
        m_addr = q.pop_back();
        m_wr   = 1;
      end
    end else if (c) begin
      if (q.size() == D) m_err = 1;
      else begin
        q.push_back((p + 1) % (1 << PW));
        m_addr = t % (1 << PW);
        m_wr   = 1;
      end
    end else if (j) begin
      m_addr = t % (1 << PW);
      m_wr   = 1;
    end
    check_all();
  endtask

  task automatic idle();
    step(0, 0, 0, 0, 0);
  endtask

  // Assert reset between edges, check it takes effect at once, release mid-cycle.
  task automatic pulse_reset();
    #2;
    res = 1'b1;
    #1;
    model_reset();
    check_all();
    @(posedge clk);
    #1;
    check_all();
    res = 1'b0;
  endtask

  initial begin
    bus.jmp_req  = 1'b0;
    bus.call_req = 1'b0;
    bus.ret_req  = 1'b0;
    bus.pc       = '0;
    bus.target   = '0;
    model_reset();
    #1;
    check_all();
    @(posedge clk);
    #1;
    res = 1'b0;
    check_all();

    // Call then return
    step(0, 1, 0, 5, 32);
    step(0, 0, 1, 0, 0);
    idle();

    // Jump
    step(1, 0, 0, 0, 200);
    idle();

    // Fill, overflow, unwind
    for (int i = 10; i < 18; i++) step(0, 1, 0, i, 100 + i);
    step(0, 1, 0, 18, 150);
    for (int i = 0; i < 8; i++) step(0, 0, 1, 0, 0);
    idle();

    // Return on empty stack from reset state; err sticky until reset
    pulse_reset();
    step(0, 0, 1, 0, 0);
    idle();
    idle();
    pulse_reset();

    // Conflict call+jmp with wrapping pc
    step(1, 1, 0, 255, 40);
    step(0, 0, 1, 0, 0);
    pulse_reset();

    // Reset in the middle of a call burst
    for (int i = 0; i < 4; i++) step(0, 1, 0, 60 + i, 90 + i);
    pulse_reset();
    step(0, 1, 0, 70, 80);
    step(0, 0, 1, 0, 0);

    // Randomized traffic with periodic resets to clear sticky err
    for (int n = 0; n < 1500; n++) begin
      int sel;
      int p;
      bit j, c, r;
      sel = $urandom_range(0, 19);
      p   = ($urandom_range(0, 7) == 0) ? 255 : $urandom_range(0, 255);
      j = 0; c = 0; r = 0;
      if (sel < 3) begin
      end else if (sel < 7) j = 1;
      else if (sel < 12) c = 1;
      else if (sel < 17) r = 1;
      else begin
        j = $urandom_range(0, 1);
        c = $urandom_range(0, 1);
        r = $urandom_range(0, 1);
      end
      step(j, c, r, p, $urandom_range(0, 255));
      if (n % 150 == 149) pulse_reset();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/call_stack_ctrl.md
# call_stack_ctrl

Control-flow stage directly upstream of the program counter: turns jump, call and return requests from the decoder into the one-cycle load strobe and load address the program counter consumes. Calls push the return address (current pc + 1) onto an internal LIFO, and returns pop it. Overflow, underflow and conflicting requests are flagged, never silently acted on.

## Interface
Parameters:
- PC_WIDTH, 8, width of pc, target and load address
- DEPTH, 8, return-stack entries; power of two, at least 2

Ports:
- clk  in  1  system clock, rising edge
- res  in  1  asynchronous, active-high reset
- pc  in  PC_WIDTH  current program counter value
- jmp_req  in  1  unconditional jump to target
- call_req  in  1  call to target; push pc+1
- ret_req  in  1  return; pop the top entry
- target  in  PC_WIDTH  jump/call destination
- wr_en  out  1  load strobe to the program counter
- counteradress  out  PC_WIDTH  load address to the program counter
- depth  out  $clog2(DEPTH)+1  number of valid stack entries
- empty  out  1  depth == 0
- full  out  1  depth == DEPTH
- err  out  1  sticky error flag

## Operation
- Reset (async, res=1): wr_en=0, counteradress=0, depth=0, empty=1, full=0, err=0. Stack contents are don't-care.
- Requests are sampled on every rising edge. All outputs are registered.
- At most one request may be active per cycle. If more than one is active, err is set and the highest-priority request is serviced. Priority: ret_req > call_req > jmp_req.
- jmp: counteradress <= target, wr_en <= 1. The stack is unchanged.
- call, not full: stack[depth] <= pc+1 (mod 2^PC_WIDTH), depth+1, counteradress <= target, wr_en <= 1.
- call, full: no push, wr_en <= 0, counteradress holds, err <= 1.
- ret, not empty: counteradress <= stack[depth-1], depth-1, wr_en <= 1.
- ret, empty: no pop, wr_en <= 0, counteradress holds, err <= 1.
- No request: wr_en <= 0. counteradress holds its last value.
- pc = 2^PC_WIDTH-1 on a call pushes 0. The wrap is legal and does not set err.
- err clears only on reset.
- Reset asserted mid-operation clears everything immediately, regardless of clk.

## Timing
- Latency 1: a request sampled at edge N gives wr_en=1 and a valid counteradress after edge N, for exactly one cycle. The program counter loads at edge N+1.
- Back-to-back requests are accepted every cycle, with no bubbles. wr_en stays high on consecutive cycles.
- depth, empty and full update on the same edge as the push or pop.
- Requests sampled in the cycle after reset deassertion are serviced normally.

## Structure
- Shared package pc_pkg:
  - PC_WIDTH default.
  - Request encoding enum ctl_req_t {REQ_NONE, REQ_JMP, REQ_CALL, REQ_RET}, produced by a priority encoder in this block.
- Sub-module addr_stack holds the LIFO storage array and the depth pointer.
  - Ports: clk, res, push, pop, din, dout, depth, empty, full.
  - The parent guards push/pop against full/empty.
- The parent holds the priority and error logic and the output registers.

## Test plan
- Reset, then call_req with pc=5, target=32 -> next cycle wr_en=1, counteradress=32, depth=1; then ret_req -> wr_en=1, counteradress=6, depth=0, empty=1.
- jmp_req with target=200 -> one-cycle wr_en=1, counteradress=200, depth unchanged, err=0.
- Eight nested calls (pc=10..17), a ninth call -> full=1, ninth gives wr_en=0, err=1; eight rets -> counteradress 18,17,…,11 in LIFO order.
- ret_req at reset state (empty) -> wr_en=0, counteradress=0, err=1 held until res pulse clears it.
- call_req and jmp_req same cycle, pc=255, target=40 -> call serviced: counteradress=40, pushed value 0, err=1.
- res asserted between clock edges during a call burst -> outputs return to reset values immediately, before the next edge; the first request after release is serviced normally.
